sound_mailbox: RTL

SOUND_MAILBOX -- requirements
Module: sound_mailbox

---
 rtl/sound_mailbox_pkg.sv | 14 +
 rtl/mbox_fifo.sv | 70 +++++++
 rtl/sound_mailbox.sv | 116 +++++++++++
 3 files changed

// File: rtl/sound_mailbox_pkg.sv
// Shared constants for the sound mailbox: default geometry and STATUS bit map.
package sound_mailbox_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 4;

  // STATUS = {OVF, RPY_VALID, CMD_FULL, CMD_EMPTY}
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_RVALID = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_W      = 4;

endpackage

// File: rtl/mbox_fifo.sv
// Small synchronous FIFO with a registered read port.
// A pop loads the head entry into dout one edge later; dout holds otherwise.
// A push while full is dropped unless a pop is accepted in the same cycle,
// in which case both go through and the occupancy stays at DEPTH.
// ovf pulses for one cycle on every dropped push.
module mbox_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop only happens with data present; a full FIFO still takes a push
  // when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && !do_push;

  // Pointers, occupancy and the registered read port.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the simultaneous full push/pop relies on this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately left out of reset; entries are only ever
  // read behind a valid count, so stale contents can never reach dout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sound_mailbox.sv
// 68K <-> Z80 sound mailbox: a command FIFO toward the Z80 with a level NMI
// request, a reply path back to the 68K, and a sticky overflow flag.
// Build option: define MAILBOX_REPLY_FIFO_EN to make the reply path a second
// FIFO; by default the reply path is a single overwrite register.
module sound_mailbox
  import sound_mailbox_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            CLK_24M,
  input  logic            RESET,
  input  logic            CMD_WR,
  input  logic [DW-1:0]   CMD_DIN,
  input  logic            CMD_RD,
  output logic [DW-1:0]   CMD_DOUT,
  input  logic            RPY_WR,
  input  logic [DW-1:0]   RPY_DIN,
  input  logic            RPY_RD,
  output logic [DW-1:0]   RPY_DOUT,
  input  logic            NMI_ACK,
  output logic            Z80_NMI,
  output logic [ST_W-1:0] STATUS,
  input  logic            CLR_OVF
);

  logic cmd_empty;
  logic cmd_full;
  logic cmd_ovf;
  logic cmd_push_ok;
  logic rpy_ovf;
  logic rpy_valid;
  logic ovf;

  mbox_fifo #(.DW(DW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (CLK_24M),
    .rst   (RESET),
    .push  (CMD_WR),
    .din   (CMD_DIN),
    .pop   (CMD_RD),
    .dout  (CMD_DOUT),
    .empty (cmd_empty),
    .full  (cmd_full),
    .ovf   (cmd_ovf)
  );

  // Every push the FIFO did not drop counts as a new command for the Z80.
  assign cmd_push_ok = CMD_WR && !cmd_ovf;

`ifdef MAILBOX_REPLY_FIFO_EN
  logic rpy_empty;
  logic rpy_full_unused;

  mbox_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rpy_fifo (
    .clk   (CLK_24M),
    .rst   (RESET),
    .push  (RPY_WR),
    .din   (RPY_DIN),
    .pop   (RPY_RD),
    .dout  (RPY_DOUT),
    .empty (rpy_empty),
    .full  (rpy_full_unused),
    .ovf   (rpy_ovf)
  );

  assign rpy_valid = !rpy_empty;
`else
  logic [DW-1:0] rpy_reg;

  // The reply register never overflows: a new reply simply replaces the old.
  assign rpy_ovf = 1'b0;

  // Reply latch: a write always overwrites the held reply.
  always_ff @(posedge CLK_24M) begin
    if (RPY_WR) rpy_reg <= RPY_DIN;
  end

  // Reply read port and valid flag; a coincident write keeps valid set while
  // the read still returns the previously held reply.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      RPY_DOUT  <= '0;
      rpy_valid <= 1'b0;
    end else begin
      if (RPY_RD && rpy_valid) RPY_DOUT <= rpy_reg;
      if (RPY_WR)      rpy_valid <= 1'b1;
      else if (RPY_RD) rpy_valid <= 1'b0;
    end
  end
`endif

  // NMI request and sticky overflow; a set event beats a coincident clear.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      Z80_NMI <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (cmd_push_ok)  Z80_NMI <= 1'b1;
      else if (NMI_ACK) Z80_NMI <= 1'b0;

      if (cmd_ovf || rpy_ovf) ovf <= 1'b1;
      else if (CLR_OVF)       ovf <= 1'b0;
    end
  end

  // Status word assembled from the package bit map.
  // NOTE: every bit gets a default first so this block can never infer a latch.
  always_comb begin
    STATUS            = '0;
    STATUS[ST_EMPTY]  = cmd_empty;
    STATUS[ST_FULL]   = cmd_full;
    STATUS[ST_RVALID] = rpy_valid;
    STATUS[ST_OVF]    = ovf;
  end

endmodule
